// File: rtl/alu_rr_sched_if.sv
// Requester/response/ALU bundle for the round-robin ALU scheduler.
// master = scheduler side, slave = requesters, consumer and ALU.
interface alu_rr_sched_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*4-1:0]     req_s;
  logic [NREQ-1:0]       ack;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_acc;
  logic [WIDTH-1:0]      rsp_mulh;
  logic [7:0]            rsp_flag;
  logic                  rsp_err;

  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [3:0]            alu_s;
  logic [WIDTH-1:0]      alu_acc;
  logic [WIDTH-1:0]      alu_mulh;
  logic [7:0]            alu_flag;

  modport master (
    input  req, req_a, req_b, req_s, rsp_ready, alu_acc, alu_mulh, alu_flag,
    output ack, rsp_valid, rsp_id, rsp_acc, rsp_mulh, rsp_flag, rsp_err,
           alu_a, alu_b, alu_s
  );

  modport slave (
    output req, req_a, req_b, req_s, rsp_ready, alu_acc, alu_mulh, alu_flag,
    input  ack, rsp_valid, rsp_id, rsp_acc, rsp_mulh, rsp_flag, rsp_err,
           alu_a, alu_b, alu_s
  );
endinterface

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one combinational ALU among NREQ requesters.
// IDLE grants and latches operands, EXEC captures ALU outputs, RESP holds until handshake.
module alu_rr_sched #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  alu_rr_sched_if.master io_bus
);
  localparam logic [3:0] OP_PASS = 4'b1011;
  localparam logic [3:0] OP_REJ  = 4'b1000;
  localparam logic [3:0] OP_MULH = 4'b1110;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_alu_a, r_alu_b;
  logic [3:0]       r_alu_s;
  logic             r_rej;
  logic             r_valid;
  logic [WIDTH-1:0] r_acc, r_mulh;
  logic [7:0]       r_flag;
  logic             r_err;

  logic [NREQ-1:0][WIDTH-1:0] w_a, w_b;
  logic [NREQ-1:0][3:0]       w_s;
  logic                       w_any;
  logic [IDW-1:0]             w_gnt;
  logic [IDW:0]               w_sum;
  logic [NREQ-1:0]            w_ack;

  assign w_a = io_bus.req_a;
  assign w_b = io_bus.req_b;
  assign w_s = io_bus.req_s;

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_sum = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
      if (io_bus.req[w_sum[IDW-1:0]]) begin
        w_any = 1'b1;
        w_gnt = w_sum[IDW-1:0];
      end
    end
  end

  // ack is combinational in IDLE so the requester sees it in the grant cycle
  // and may re-raise req for its next operation on the following edge.
  always_comb begin
    w_ack = '0;
    if (r_state == IDLE && !i_rst && w_any) w_ack[w_gnt] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_alu_s <= OP_PASS;
      r_rej   <= 1'b0;
      r_valid <= 1'b0;
      r_acc   <= '0;
      r_mulh  <= '0;
      r_flag  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_alu_a <= w_a[w_gnt];
          r_alu_b <= w_b[w_gnt];
          r_rej   <= (w_s[w_gnt] == OP_REJ);
          r_alu_s <= (w_s[w_gnt] == OP_REJ) ? OP_PASS : w_s[w_gnt];
          r_id    <= w_gnt;
          r_ptr   <= (w_gnt == IDW'(NREQ-1)) ? '0 : w_gnt + 1'b1;
          r_state <= EXEC;
        end
        EXEC: begin
          r_acc   <= r_rej ? '0 : io_bus.alu_acc;
          r_flag  <= r_rej ? '0 : io_bus.alu_flag;
          r_mulh  <= (!r_rej && r_alu_s == OP_MULH) ? io_bus.alu_mulh : '0;
          r_err   <= r_rej;
          r_valid <= 1'b1;
          r_state <= RESP;
        end
        RESP: if (io_bus.rsp_ready) begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.ack       = w_ack;
  assign io_bus.rsp_valid = r_valid;
  assign io_bus.rsp_id    = r_id;
  assign io_bus.rsp_acc   = r_acc;
  assign io_bus.rsp_mulh  = r_mulh;
  assign io_bus.rsp_flag  = r_flag;
  assign io_bus.rsp_err   = r_err;
  assign io_bus.alu_a     = r_alu_a;
  assign io_bus.alu_b     = r_alu_b;
  assign io_bus.alu_s     = r_alu_s;
endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched with a behavioural ALU on the shared port.
module tb_alu_rr_sched;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_rr_sched_if #(.WIDTH(W), .NREQ(N), .IDW(IW)) bus ();
  alu_rr_sched #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  acc;
    logic [W-1:0]  mulh;
    logic [7:0]    flag;
    logic          err;
  } rsp_t;

  rsp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // mulh is deliberately non-zero for every opcode so the scheduler must mask it.
  function automatic logic [71:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    logic [31:0] acc, mulh;
    logic [63:0] p;
    logic [7:0]  fl;
    logic        c;
    p = 64'(a) * 64'(b);
    c = 1'b0;
    mulh = ~a;
    case (s)
      4'b0000: acc = a & b;
      4'b0001: acc = a | b;
      4'b0010: acc = a ^ b;
      4'b1001: {c, acc} = 33'(a) + 33'(b);
      4'b1010: {c, acc} = 33'(a) - 33'(b);
      4'b1011: acc = a;
      4'b1110: begin acc = p[31:0]; mulh = p[63:32]; end
      default: acc = a ^ {b[15:0], b[31:16]};
    endcase
    fl = '0;
    fl[0] = ^acc;
    fl[4] = (acc == 32'd0);
    fl[6] = c;
    fl[7] = acc[31];
    return {mulh, acc, fl};
  endfunction

  assign {bus.alu_mulh, bus.alu_acc, bus.alu_flag} = alu_f(bus.alu_a, bus.alu_b, bus.alu_s);

  function automatic rsp_t expect_rsp(input int id, input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] s);
    rsp_t r;
    logic [71:0] o;
    r.id = IW'(id);
    if (s == 4'b1000) begin
      r.acc = '0; r.mulh = '0; r.flag = '0; r.err = 1'b1;
    end else begin
      o = alu_f(a, b, s);
      r.mulh = (s == 4'b1110) ? o[71:40] : '0;
      r.acc  = o[39:8];
      r.flag = o[7:0];
      r.err  = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard: push on grant from the driven operands, pop on response handshake.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst) sb.delete();
      else begin
        if (bus.ack != '0) begin
          int g;
          g = 0;
          for (int i = 0; i < N; i++) if (bus.ack[i]) g = i;
          chk("ack_onehot", 64'($onehot(bus.ack)), 64'd1);
          sb.push_back(expect_rsp(g, bus.req_a[g*W +: W], bus.req_b[g*W +: W], bus.req_s[g*4 +: 4]));
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (sb.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
          else begin
            rsp_t e;
            e = sb.pop_front();
            chk("sb_id",   bus.rsp_id,   e.id);
            chk("sb_acc",  bus.rsp_acc,  e.acc);
            chk("sb_mulh", bus.rsp_mulh, e.mulh);
            chk("sb_flag", bus.rsp_flag, e.flag);
            chk("sb_err",  bus.rsp_err,  e.err);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d miscompares so far", n_err);
    $fatal(1);
  end

  task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    bit hit;
    hit = 1'b0;
    @(negedge clk);
    bus.req_a[idx*W +: W] = a;
    bus.req_b[idx*W +: W] = b;
    bus.req_s[idx*4 +: 4] = s;
    bus.req[idx] = 1'b1;
    for (int c = 0; c < 20 && !hit; c++) begin
      #1;
      if (bus.ack[idx]) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  // Returns in the first response cycle with the response on the outputs.
  task automatic op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    issue(idx, a, b, s);
    chk("op_ack", bus.ack, 64'd1 << idx);
    @(negedge clk);
    bus.req[idx] = 1'b0;
    #1;
    chk("op_lat1", bus.rsp_valid, 1'b0);
    chk("op_alu_s", bus.alu_s, (s == 4'b1000) ? 4'b1011 : s);
    chk("op_alu_a", bus.alu_a, a);
    @(negedge clk); #1;
    chk("op_valid", bus.rsp_valid, 1'b1);
    chk("op_id", bus.rsp_id, idx);
  endtask

  initial begin
    int   k, last;
    rsp_t e;
    bus.req = '0; bus.req_a = '0; bus.req_b = '0; bus.req_s = '0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = 32'h100 + 32'(i);
      bus.req_b[i*W +: W] = 32'(i);
      bus.req_s[i*4 +: 4] = 4'b1001;
    end
    bus.req = '1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ack",   bus.ack, 4'b0000);
    chk("rst_valid", bus.rsp_valid, 1'b0);
    chk("rst_alu_s", bus.alu_s, 4'b1011);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_id",    bus.rsp_id, 2'd0);
    chk("rst_acc",   bus.rsp_acc, 32'd0);
    chk("rst_mulh",  bus.rsp_mulh, 32'd0);
    chk("rst_flag",  bus.rsp_flag, 8'd0);
    chk("rst_err",   bus.rsp_err, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_first_ack", bus.ack, 4'b0001);
    @(negedge clk);
    bus.req = '0;
    repeat (4) @(negedge clk);

    op(2, 32'hFFFF_FFFF, 32'd1, 4'b1001);
    chk("add_acc",  bus.rsp_acc, 32'd0);
    chk("add_zero", bus.rsp_flag[4], 1'b1);
    chk("add_cry",  bus.rsp_flag[6], 1'b1);
    chk("add_mulh", bus.rsp_mulh, 32'd0);

    op(1, 32'h8000_0000, 32'd4, 4'b1110);
    chk("mul_acc",  bus.rsp_acc, 32'd0);
    chk("mul_mulh", bus.rsp_mulh, 32'h0000_0002);

    op(3, 32'd5, 32'd7, 4'b1000);
    chk("rej_err",   bus.rsp_err, 1'b1);
    chk("rej_acc",   bus.rsp_acc, 32'd0);
    chk("rej_mulh",  bus.rsp_mulh, 32'd0);
    chk("rej_flag",  bus.rsp_flag, 8'd0);
    chk("rej_alu_s", bus.alu_s, 4'b1011);

    // Fairness: all requesters held high, grants must rotate 3 cycles apart.
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = 32'h1111_1111 * 32'(i + 1);
      bus.req_b[i*W +: W] = 32'(i + 3);
    end
    bus.req_s = {4'b1010, 4'b1110, 4'b0001, 4'b0000};
    bus.req = '1;
    k = 0;
    last = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      #1;
      if (bus.ack != '0) begin
        chk("fair_ack", bus.ack, 64'd1 << (k % N));
        if (k > 0) chk("fair_gap", 64'(c - last), 64'd3);
        last = c;
        k++;
      end
      if (k < 5) @(negedge clk);
    end
    if (k < 5) chk("fair_timeout", 64'(k), 64'd5);
    @(negedge clk);
    bus.req = '0;
    repeat (3) @(negedge clk);

    // Backpressure: response and ALU inputs hold, no other grant meanwhile.
    bus.rsp_ready = 1'b0;
    bus.req_a[0 +: W] = 32'hCAFE_0001; bus.req_b[0 +: W] = 32'd9; bus.req_s[0 +: 4] = 4'b1001;
    bus.req_a[2*W +: W] = 32'h1234_5678; bus.req_b[2*W +: W] = 32'h0F0F_0F0F; bus.req_s[8 +: 4] = 4'b0010;
    bus.req = 4'b0101;
    #1;
    chk("bp_ack", bus.ack, 4'b0100);
    e = expect_rsp(2, 32'h1234_5678, 32'h0F0F_0F0F, 4'b0010);
    @(negedge clk);
    bus.req[2] = 1'b0;
    @(negedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.rsp_valid, 1'b1);
      chk("bp_ack0",  bus.ack, 4'b0000);
      chk("bp_acc",   bus.rsp_acc, e.acc);
      chk("bp_flag",  bus.rsp_flag, e.flag);
      chk("bp_alu_a", bus.alu_a, 32'h1234_5678);
      chk("bp_alu_s", bus.alu_s, 4'b0010);
      @(negedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_resume", bus.ack, 4'b0001);
    @(negedge clk);
    bus.req[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during EXEC discards the in-flight operation and rewinds ptr.
    issue(2, 32'hDEAD_0000, 32'h0000_1234, 4'b0001);
    @(negedge clk);
    bus.req[2] = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mr_valid", bus.rsp_valid, 1'b0);
    chk("mr_ack",   bus.ack, 4'b0000);
    chk("mr_alu_s", bus.alu_s, 4'b1011);
    chk("mr_alu_a", bus.alu_a, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("mr_no_rsp", bus.rsp_valid, 1'b0);
    end
    @(negedge clk);
    bus.req = '1;
    #1;
    chk("mr_ptr0", bus.ack, 4'b0001);
    @(negedge clk);
    bus.req = '0;
    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
